// File: rtl/tss_rx_deframer.sv
// Receive-side deframer: gathers byte frames into command words, timestamps them at frame
// start, and queues them in a small FIFO that software drains over a Wishbone slave port.
module tss_rx_deframer #(
    parameter int unsigned CMD_BYTES       = 8,
    parameter int unsigned TIMESTAMP_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [7:0]                 tss_axis_tdata,
    input  logic                       tss_axis_tvalid,
    output logic                       tss_axis_tready,
    input  logic                       tss_axis_tlast,
    input  logic                       timer_valid_i,
    input  logic [TIMESTAMP_WIDTH-1:0] timer_i,
    input  logic                       wbs_we_i,
    input  logic [31:0]                wbs_addr_i,
    input  logic [31:0]                wbs_data_i,
    output logic [31:0]                wbs_data_o,
    input  logic                       wbs_stb_i,
    output logic                       wbs_ack_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0] CMD_LEN = 4'(CMD_BYTES);
    localparam logic [63:0] CMD_MASK = {64{1'b1}} >> (64 - 8 * CMD_BYTES);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDiscard
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [63:0] sr_q, sr_d;
    logic [63:0] pts_q, pts_d;
    logic ptsv_q, ptsv_d;
    logic commit_req, commit_tsv, short_inc, long_inc;
    logic [63:0] commit_cmd, commit_ts, timer_ext;
    logic beat;

    logic [63:0] cmd_mem [FIFO_DEPTH];
    logic [63:0] ts_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] tsv_mem;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic empty, full, push, pop, ovf_inc;
    logic [63:0] head_cmd, head_ts;
    logic head_tsv;

    logic [7:0] short_q, long_q, ovf_q;
    logic [31:0] frames_q;
    logic wb_req, err_clr, ack_q;
    logic [31:0] rdata, rdata_q;
    logic unused_bits;

    assign unused_bits = ^{wbs_addr_i[31:5], wbs_addr_i[1:0], wbs_data_i};

    assign tss_axis_tready = ~arst;
    assign beat = tss_axis_tvalid & tss_axis_tready;
    assign timer_ext = 64'(timer_i);

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            pts_q   <= '0;
            ptsv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            pts_q   <= pts_d;
            ptsv_q  <= ptsv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        pts_d      = pts_q;
        ptsv_d     = ptsv_q;
        commit_req = 1'b0;
        short_inc  = 1'b0;
        long_inc   = 1'b0;
        commit_ts  = pts_q;
        commit_tsv = ptsv_q;
        case (state_q)
            StIdle: begin
                if (beat) begin
                    sr_d       = {56'd0, tss_axis_tdata};
                    cnt_d      = 4'd1;
                    pts_d      = timer_ext;
                    ptsv_d     = timer_valid_i;
                    // A one-byte frame commits with the timestamp captured this very cycle
                    commit_ts  = timer_ext;
                    commit_tsv = timer_valid_i;
                    if (tss_axis_tlast) begin
                        if (CMD_BYTES == 1) commit_req = 1'b1;
                        else                short_inc  = 1'b1;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (beat) begin
                    sr_d  = {sr_q[55:0], tss_axis_tdata};
                    cnt_d = cnt_q + 4'd1;
                    if (tss_axis_tlast) begin
                        if (cnt_d == CMD_LEN) commit_req = 1'b1;
                        else                  short_inc  = 1'b1;
                        state_d = StIdle;
                    end else if (cnt_d == CMD_LEN) begin
                        long_inc = 1'b1;
                        state_d  = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (beat && tss_axis_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        commit_cmd = sr_d & CMD_MASK;
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == FIFO_FULL);
    assign head_cmd = cmd_mem[rd_ptr_q];
    assign head_ts  = ts_mem[rd_ptr_q];
    assign head_tsv = ~empty & tsv_mem[rd_ptr_q];

    assign wb_req  = wbs_stb_i & ~ack_q;
    assign pop     = wb_req & wbs_we_i & (wbs_addr_i[4:2] == 3'd5) & ~empty;
    assign err_clr = wb_req & wbs_we_i & (wbs_addr_i[4:2] == 3'd6);
    // A pop in the same cycle frees the slot the full FIFO needs
    assign push    = commit_req & (~full | pop);
    assign ovf_inc = commit_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q] <= commit_cmd;
            ts_mem[wr_ptr_q]  <= commit_ts;
            tsv_mem[wr_ptr_q] <= commit_tsv;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst || err_clr) begin
            short_q <= '0;
            long_q  <= '0;
            ovf_q   <= '0;
        end else begin
            if (short_inc && short_q != 8'hFF) short_q <= short_q + 8'd1;
            if (long_inc && long_q != 8'hFF)   long_q  <= long_q + 8'd1;
            if (ovf_inc && ovf_q != 8'hFF)     ovf_q   <= ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst)      frames_q <= '0;
        else if (push) frames_q <= frames_q + 32'd1;
    end

    always_comb begin
        rdata = '0;
        case (wbs_addr_i[4:2])
            3'd0:    rdata = {21'd0, head_tsv, full, empty, 4'd0, 4'(count_q)};
            3'd1:    rdata = empty ? 32'd0 : head_cmd[31:0];
            3'd2:    rdata = empty ? 32'd0 : head_cmd[63:32];
            3'd3:    rdata = empty ? 32'd0 : head_ts[31:0];
            3'd4:    rdata = empty ? 32'd0 : head_ts[63:32];
            3'd6:    rdata = {8'd0, ovf_q, long_q, short_q};
            3'd7:    rdata = frames_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= wb_req;
            rdata_q <= wb_req ? rdata : 32'd0;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_data_o = rdata_q;

endmodule

// File: tb/tb_tss_rx_deframer.sv
// Directed bench for tss_rx_deframer: framing, errors, FIFO overflow, bus timing and reset.
module tb_tss_rx_deframer;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tready;
    logic        timer_valid;
    logic [63:0] timer;
    logic        we, stb, ack;
    logic [31:0] addr, wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int RegStatus = 0;
    localparam int RegCmdLo  = 1;
    localparam int RegCmdHi  = 2;
    localparam int RegTsLo   = 3;
    localparam int RegTsHi   = 4;
    localparam int RegPop    = 5;
    localparam int RegErr    = 6;
    localparam int RegFrames = 7;

    always #5 clk = ~clk;

    tss_rx_deframer #(
        .CMD_BYTES      (8),
        .TIMESTAMP_WIDTH(64),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .tss_axis_tdata (tdata),
        .tss_axis_tvalid(tvalid),
        .tss_axis_tready(tready),
        .tss_axis_tlast (tlast),
        .timer_valid_i  (timer_valid),
        .timer_i        (timer),
        .wbs_we_i       (we),
        .wbs_addr_i     (addr),
        .wbs_data_i     (wdata),
        .wbs_data_o     (rdata),
        .wbs_stb_i      (stb),
        .wbs_ack_o      (ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic wb_read(input int idx, output logic [31:0] d);
        addr = 32'(idx) << 2;
        we   = 1'b0;
        stb  = 1'b1;
        @(negedge clk);
        check("read_ack", ack, 1);
        d   = rdata;
        stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(idx, d);
        check(tag, d, exp);
    endtask

    task automatic wb_write(input int idx, input logic [31:0] d);
        addr  = 32'(idx) << 2;
        wdata = d;
        we    = 1'b1;
        stb   = 1'b1;
        @(negedge clk);
        check("write_ack", ack, 1);
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_beats(input logic [7:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            tdata  = base + 8'(i);
            tvalid = 1'b1;
            tlast  = last && (i == n - 1);
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        int acks;
        arst = 1'b1; tdata = '0; tvalid = 0; tlast = 0; timer_valid = 0; timer = '0;
        we = 0; stb = 0; addr = '0; wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready", tready, 0);
        check("rst_ack", ack, 0);
        check("rst_data", rdata, 0);
        arst = 1'b0;
        @(negedge clk);
        check("tready", tready, 1);
        read_check("rst_status", RegStatus, 32'h100);
        read_check("rst_err", RegErr, 32'h0);
        read_check("rst_frames", RegFrames, 32'h0);
        read_check("rst_cmd_lo", RegCmdLo, 32'h0);

        // Good frame
        timer_valid = 1'b1;
        timer = 64'h0000_0001_2345_6789;
        send_beats(8'h01, 8, 1);
        timer_valid = 1'b0;
        timer = 64'h55;
        read_check("good_cmd_hi", RegCmdHi, 32'h01020304);
        read_check("good_cmd_lo", RegCmdLo, 32'h05060708);
        read_check("good_ts_hi", RegTsHi, 32'h00000001);
        read_check("good_ts_lo", RegTsLo, 32'h23456789);
        read_check("good_status", RegStatus, 32'h401);
        read_check("good_frames", RegFrames, 32'h1);
        wb_write(RegPop, 32'h0);
        read_check("pop_status", RegStatus, 32'h100);

        // Short then long frame
        send_beats(8'h01, 3, 1);
        send_beats(8'h01, 10, 1);
        read_check("sl_err", RegErr, 32'h00000101);
        read_check("sl_status", RegStatus, 32'h100);
        read_check("sl_cmd_lo", RegCmdLo, 32'h0);
        wb_write(RegErr, 32'h0);
        read_check("sl_err_clr", RegErr, 32'h0);

        // Overflow: five frames into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send_beats(8'((k << 4) | 1), 8, 1);
        read_check("ovf_status", RegStatus, 32'h204);
        read_check("ovf_err", RegErr, 32'h00010000);
        read_check("ovf_frames", RegFrames, 32'h5);
        read_check("ovf_head", RegCmdHi, 32'h11121314);

        // Last beat of a good frame lands on the POP edge while full
        timer_valid = 1'b1;
        timer = 64'h0000_00AB_CDEF_0123;
        send_beats(8'h61, 7, 0);
        tdata = 8'h68; tvalid = 1'b1; tlast = 1'b1;
        addr = 32'(RegPop) << 2; we = 1'b1; stb = 1'b1;
        @(negedge clk);
        check("sim_ack", ack, 1);
        tvalid = 1'b0; tlast = 1'b0; stb = 1'b0; we = 1'b0;
        timer_valid = 1'b0;
        @(negedge clk);
        read_check("sim_status", RegStatus, 32'h204);
        read_check("sim_err", RegErr, 32'h00010000);
        read_check("sim_frames", RegFrames, 32'h6);
        read_check("sim_head", RegCmdHi, 32'h21222324);
        wb_write(RegFrames, 32'h0);
        read_check("ro_frames", RegFrames, 32'h6);
        repeat (3) wb_write(RegPop, 32'h0);
        read_check("tail_cmd_hi", RegCmdHi, 32'h61626364);
        read_check("tail_cmd_lo", RegCmdLo, 32'h65666768);
        read_check("tail_ts_hi", RegTsHi, 32'h000000AB);
        read_check("tail_ts_lo", RegTsLo, 32'hCDEF0123);
        read_check("tail_status", RegStatus, 32'h401);
        wb_write(RegPop, 32'h0);
        read_check("drain_status", RegStatus, 32'h100);
        wb_write(RegPop, 32'h0);
        read_check("empty_pop_status", RegStatus, 32'h100);

        // Reset in the middle of a frame
        timer_valid = 1'b1;
        send_beats(8'hA1, 4, 0);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        send_beats(8'h81, 8, 1);
        timer_valid = 1'b0;
        read_check("mid_status", RegStatus, 32'h401);
        read_check("mid_cmd_hi", RegCmdHi, 32'h81828384);
        read_check("mid_cmd_lo", RegCmdLo, 32'h85868788);
        read_check("mid_err", RegErr, 32'h0);
        read_check("mid_frames", RegFrames, 32'h1);

        // Saturation: single-beat frames are short frames
        for (int i = 0; i < 300; i++) begin
            tdata = 8'h33; tvalid = 1'b1; tlast = 1'b1;
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0;
        read_check("sat_err", RegErr, 32'h000000FF);

        // Held strobe gives an ack every other cycle
        addr = 32'(RegFrames) << 2; we = 1'b0; stb = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0;
        @(negedge clk);
        check("held_stb_acks", acks, 3);
        wb_write(RegErr, 32'h0);
        read_check("sat_err_clr", RegErr, 32'h0);

        // Increment and clear on the same edge: clear wins
        tdata = 8'h44; tvalid = 1'b1; tlast = 1'b1;
        addr = 32'(RegErr) << 2; we = 1'b1; stb = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        read_check("clr_wins", RegErr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tss_rx_deframer.md
TSS_RX_DEFRAMER -- requirements
Module: tss_rx_deframer

Interface
REQ-001 Parameter CMD_BYTES, 8, bytes per command frame (legal 1..8); command word width is 8*CMD_BYTES, right-aligned in 64 bits.
REQ-002 Parameter TIMESTAMP_WIDTH, 64, width of timer_i (legal 33..64).
REQ-003 Parameter FIFO_DEPTH, 4, received-frame buffer entries (power of 2, 2..8).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 arst  input  1  reset; synchronous, active-high.
REQ-006 tss_axis_tdata  input  8  received byte, first byte is command MSB.
REQ-007 tss_axis_tvalid  input  1  byte valid.
REQ-008 tss_axis_tready  output  1  byte accepted when tvalid&tready.
REQ-009 tss_axis_tlast  input  1  last byte of frame.
REQ-010 timer_valid_i  input  1  timer_i is valid this cycle.
REQ-011 timer_i  input  TIMESTAMP_WIDTH  local time.
REQ-012 wbs_we_i  input  1  Wishbone write strobe qualifier.
REQ-013 wbs_addr_i  input  32  byte address; bits [4:2] select register.
REQ-014 wbs_data_i  input  32  write data.
REQ-015 wbs_data_o  output  32  read data, valid with wbs_ack_o.
REQ-016 wbs_stb_i  input  1  bus request.
REQ-017 wbs_ack_o  output  1  bus acknowledge.

Function
REQ-018 tss_axis_tready SHALL be 1 in every cycle except while arst is high; there is no backpressure, and frames that do not fit are dropped (REQ-025).
REQ-019 FSM states: IDLE, COLLECT, DISCARD. A beat is an accepted byte (tvalid&tready). The byte counter counts beats in the current frame, including the first.
REQ-020 IDLE, on a beat: capture timer_i and timer_valid_i into the pending timestamp, load the byte into the shift register, and set the byte counter to 1.
REQ-021 IDLE, first beat with tlast: if CMD_BYTES=1, go to the commit path (REQ-024); otherwise increment the short-frame error counter and stay in IDLE.
REQ-022 IDLE, first beat without tlast: go to COLLECT.
REQ-023 COLLECT, on a beat: shift the byte in at the LSB and increment the byte counter. Then:
- tlast with count < CMD_BYTES: increment the short-frame error counter, go to IDLE.
- tlast with count = CMD_BYTES: commit (REQ-024), go to IDLE.
- no tlast with count = CMD_BYTES: increment the long-frame error counter, go to DISCARD.
REQ-024 Commit: push {command, timestamp, ts_valid} into the FIFO and increment FRAMES. The entry is visible to a Wishbone read issued in the cycle after the last beat.
REQ-025 Commit when the FIFO is full and no pop occurs in that cycle: drop the frame, increment the overflow counter, leave FRAMES unchanged. A push and a pop in the same cycle SHALL both succeed, and the count stays unchanged.
REQ-026 DISCARD: accept and ignore beats; a beat with tlast returns to IDLE. No counter changes in DISCARD.
REQ-027 Error counters are 8-bit each and saturate at 255. FRAMES is 32-bit and wraps.
REQ-028 Wishbone register map, by wbs_addr_i[4:2]:
- 0 STATUS (RO): [3:0] count, [8] empty, [9] full, [10] head ts_valid.
- 1 CMD_LO (RO): head command [31:0].
- 2 CMD_HI (RO): head command [63:32].
- 3 TS_LO (RO): head timestamp [31:0].
- 4 TS_HI (RO): head timestamp zero-extended [63:32].
- 5 POP (WO): any write pops the head; ignored when empty.
- 6 ERR (R/W): [7:0] short, [15:8] long, [23:16] overflow; any write clears all three.
- 7 FRAMES (RO).
REQ-029 Reads of head registers while the FIFO is empty SHALL return 0. Reads of the WO register and unused bits return 0. Writes to RO registers are ignored.
REQ-030 Bus handshake: with wbs_stb_i high and wbs_ack_o low, the block asserts wbs_ack_o for exactly one cycle on the next edge, with wbs_data_o registered in that same cycle. The write side effect occurs on that edge. wbs_ack_o is then low for at least one cycle, so a held stb gives one ack every 2 cycles.
REQ-031 A counter increment and an ERR clear in the same cycle: the clear wins.
REQ-032 Order of output bytes within the command word: the first byte received lands in bits [8*CMD_BYTES-1 : 8*CMD_BYTES-8].

Reset
REQ-033 While arst is high at a clock edge, the block SHALL:
- set the FSM to IDLE;
- empty the FIFO and zero the byte counter, shift register, error counters and FRAMES;
- drive tss_axis_tready=0, wbs_ack_o=0, wbs_data_o=0.
REQ-034 Reset mid-frame: the partial frame is lost. The first beat after reset is treated as a new frame start.

Verification
REQ-035 Good frame: 8 beats 01..08 with tlast on 08, timer_valid_i=1, timer_i=0x0000_0001_2345_6789 on the first beat. Required reads:
- CMD_HI=0x01020304, CMD_LO=0x05060708;
- TS_HI=0x00000001, TS_LO=0x23456789;
- STATUS=0x401; FRAMES=1.
REQ-036 Short and long frames: a 3-byte frame with tlast, then a 10-byte frame with tlast on byte 10. Required: ERR=0x00000101, FIFO empty, and reads of CMD_LO return 0.
REQ-037 Overflow: 5 good frames with no pops. Required: STATUS=0x204 (full, count 4, head ts_valid=0 when timer_valid_i was 0) and ERR[23:16]=1. After 4 POP writes, STATUS=0x100.
REQ-038 Simultaneous events: FIFO full, and the final beat of a good frame coincides with the POP write side-effect edge. Required: count stays 4, no overflow increment, FRAMES increments.
REQ-039 Reset mid-frame: arst pulsed after 4 beats, then a full 8-byte frame. Required: exactly one FIFO entry, holding only the post-reset bytes, with all counters 0 except FRAMES=1.
REQ-040 Saturation and bus timing: 300 short frames give ERR[7:0]=0xFF. With wbs_stb_i held high for 6 cycles, exactly 3 single-cycle acks are seen. A write to ERR returns it to 0.
